// File: rtl/pipe_stage_buf.sv
// Generic pipeline stage register with a 2-entry skid buffer, flush and a global hold enable.
// Optional saturating stall counter on the stall_cnt port, enabled by defining PIPE_STALL_CNT_EN.
module pipe_stage_buf #(
  parameter int unsigned       CTRL_W     = 8,
  parameter int unsigned       DATA_W     = 128,
  parameter logic [CTRL_W-1:0] RESET_CTRL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b11
  } state_t;

  state_t state;
  state_t state_next;

  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic accept;
  logic xfer;

  logic load_main_in;
  logic load_main_skid;
  logic bubble_main;
  logic load_skid_in;
  logic bubble_skid;

  // skid occupancy comes straight from the state register, so en is the only combinational term
  assign in_ready  = en & (state != SKID);
  assign out_valid = (state != EMPTY);
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;

  assign accept = in_valid & in_ready;
  assign xfer   = en & out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
    end else if (en) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) state_next = FULL;
        end
        FULL: begin
          if (accept && !xfer)      state_next = SKID;
          else if (!accept && xfer) state_next = EMPTY;
          else                      state_next = FULL;
        end
        SKID: begin
          if (xfer) state_next = FULL;
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_comb begin
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    bubble_main    = 1'b0;
    load_skid_in   = 1'b0;
    bubble_skid    = 1'b0;
    if (flush) begin
      bubble_main = 1'b1;
      bubble_skid = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          load_main_in = accept;
        end
        FULL: begin
          load_main_in = accept & xfer;
          load_skid_in = accept & ~xfer;
          bubble_main  = xfer & ~accept;
        end
        SKID: begin
          load_main_skid = xfer;
          bubble_skid    = xfer;
        end
        default: begin
          bubble_main = 1'b1;
          bubble_skid = 1'b1;
        end
      endcase
    end
  end

  // Bubbles reset only the control bundle; data keeps its last value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_ctrl <= RESET_CTRL;
      main_data <= '0;
    end else if (en) begin
      if (bubble_main) begin
        main_ctrl <= RESET_CTRL;
      end else if (load_main_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_ctrl <= RESET_CTRL;
      skid_data <= '0;
    end else if (en) begin
      if (bubble_skid) begin
        skid_ctrl <= RESET_CTRL;
      end else if (load_skid_in) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

`ifdef PIPE_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (en && out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
